// File: rtl/countdown_ctrl_if.sv
// -----------------------------------------------------------------------------
// countdown_ctrl_if
// Bundles the button/tick/finish inputs and the preset/control/display outputs
// of the countdown timer sequencing controller.
//   master : drives tick, up, down, left, right, start, finish;
//            observes preset, load, go, cursor, blink_mask, alarm, state
//   slave  : the controller side (inputs/outputs reversed)
// -----------------------------------------------------------------------------
interface countdown_ctrl_if;
  logic        tick;
  logic        up;
  logic        down;
  logic        left;
  logic        right;
  logic        start;
  logic        finish;
  logic [15:0] preset;
  logic        load;
  logic        go;
  logic [1:0]  cursor;
  logic [3:0]  blink_mask;
  logic        alarm;
  logic [2:0]  state;

  modport master (
    output tick, up, down, left, right, start, finish,
    input  preset, load, go, cursor, blink_mask, alarm, state
  );

  modport slave (
    input  tick, up, down, left, right, start, finish,
    output preset, load, go, cursor, blink_mask, alarm, state
  );
endinterface

// File: rtl/countdown_ctrl.sv
// -----------------------------------------------------------------------------
// countdown_ctrl
// Sequencing controller for the countdown timer. Turns debounced button levels
// into BCD MM:SS preset editing, a one-cycle load pulse, a count enable and
// alarm handling.
//
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : countdown_ctrl_if.slave
//          in : tick (1 Hz one-clk pulse), up/down/left/right/start levels,
//               finish (datapath reached 0000)
//          out: preset[15:0], load, go, cursor[1:0], blink_mask[3:0],
//               alarm, state[2:0] (IDLE=0 EDIT=1 RUN=2 PAUSE=3 ALARM=4)
//
// Optional build macro: AUTO_REPEAT_EN
//   When defined, holding up or down alone in EDIT repeats the step after
//   REPEAT_DELAY cycles and then every REPEAT_RATE cycles.
// -----------------------------------------------------------------------------
module countdown_ctrl #(
  parameter int unsigned ALARM_SECS   = 10,
  parameter int unsigned REPEAT_DELAY = 50000000,
  parameter int unsigned REPEAT_RATE  = 10000000
) (
  input  logic            clk,
  input  logic            rst,
  countdown_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    EDIT  = 3'd1,
    RUN   = 3'd2,
    PAUSE = 3'd3,
    ALARM = 3'd4
  } state_t;

  // Alarm counter holds 0 .. ALARM_SECS-1 ticks seen so far.
  localparam int unsigned ALARM_W = (ALARM_SECS > 1) ? $clog2(ALARM_SECS) : 1;

  // Button vector ordering: [0]=up [1]=down [2]=left [3]=right [4]=start
  logic [4:0]         btn_s;
  logic [4:0]         edge_s;
  logic [4:0]         prev_r;

  state_t             state_r, state_n;
  logic [15:0]        preset_r, preset_n;
  logic [1:0]         cursor_r, cursor_n;
  logic               load_r, load_n;
  logic               go_r, go_n;
  logic               alarm_r, alarm_n;
  logic [3:0]         blink_r, blink_n;
  logic [ALARM_W-1:0] alarm_cnt_r, alarm_cnt_n;

  logic               rep_up_s;
  logic               rep_dn_s;
  logic               up_step_s;
  logic               dn_step_s;
  logic [3:0]         cur_digit_s;
  logic [3:0]         cur_max_s;

  // Minutes/seconds tens digits (odd positions) run 0-5, units digits 0-9.
  function automatic logic [3:0] digit_max(input logic [1:0] pos);
    logic [3:0] m;
    if (pos[0]) begin
      m = 4'd5;
    end else begin
      m = 4'd9;
    end
    return m;
  endfunction

  // One wrapping BCD step up or down within 0..max.
  function automatic logic [3:0] digit_step(input logic [3:0] val,
                                            input logic [3:0] max,
                                            input logic       dir_up);
    logic [3:0] r;
    if (dir_up) begin
      if (val >= max) begin
        r = 4'd0;
      end else begin
        r = val + 4'd1;
      end
    end else begin
      if (val == 4'd0) begin
        r = max;
      end else begin
        r = val - 4'd1;
      end
    end
    return r;
  endfunction

  assign btn_s       = {bus.start, bus.right, bus.left, bus.down, bus.up};
  // Rising edge seen at this clock edge acts on the registers updated by it.
  assign edge_s      = btn_s & ~prev_r;
  assign cur_digit_s = preset_r[{cursor_r, 2'b00} +: 4];
  assign cur_max_s   = digit_max(cursor_r);

`ifdef AUTO_REPEAT_EN
  localparam int unsigned REP_W = $clog2(REPEAT_DELAY + 1);

  logic [REP_W-1:0] rep_cnt_r, rep_cnt_n;
  logic             rep_fire_s;

  // Repeat timer: counts cycles a single up/down stays held in EDIT; on
  // firing it is rewound so the next fire comes REPEAT_RATE cycles later.
  always_comb begin
    rep_cnt_n  = '0;
    rep_fire_s = 1'b0;
    if ((state_r == EDIT) && !edge_s[4] && !edge_s[0] && !edge_s[1] &&
        (bus.up ^ bus.down)) begin
      if (rep_cnt_r == REP_W'(REPEAT_DELAY - 32'd1)) begin
        rep_fire_s = 1'b1;
        rep_cnt_n  = REP_W'(REPEAT_DELAY - REPEAT_RATE);
      end else begin
        rep_cnt_n  = rep_cnt_r + REP_W'(1);
      end
    end else begin
      rep_cnt_n = '0;
    end
  end

  // Repeat timer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_cnt_r <= '0;
    end else begin
      rep_cnt_r <= rep_cnt_n;
    end
  end

  assign rep_up_s = rep_fire_s & bus.up;
  assign rep_dn_s = rep_fire_s & bus.down;
`else
  assign rep_up_s = 1'b0;
  assign rep_dn_s = 1'b0;
`endif

  assign up_step_s = edge_s[0] | rep_up_s;
  assign dn_step_s = edge_s[1] | rep_dn_s;

  // Next-state, preset/cursor editing and alarm tick counting.
  always_comb begin
    state_n     = state_r;
    preset_n    = preset_r;
    cursor_n    = cursor_r;
    load_n      = 1'b0;
    alarm_cnt_n = alarm_cnt_r;
    case (state_r)
      IDLE: begin
        if (edge_s[4]) begin
          if (preset_r != 16'h0000) begin
            state_n = RUN;
            load_n  = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end else if (|edge_s[3:0]) begin
          // Entering EDIT swallows the edge; the digit is not touched.
          state_n = EDIT;
        end else begin
          state_n = IDLE;
        end
      end
      EDIT: begin
        if (edge_s[4]) begin
          if (preset_r != 16'h0000) begin
            state_n = RUN;
            load_n  = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end else begin
          // Digit is edited at the old cursor before the cursor moves.
          if (up_step_s && !dn_step_s) begin
            preset_n[{cursor_r, 2'b00} +: 4] = digit_step(cur_digit_s, cur_max_s, 1'b1);
          end else if (dn_step_s && !up_step_s) begin
            preset_n[{cursor_r, 2'b00} +: 4] = digit_step(cur_digit_s, cur_max_s, 1'b0);
          end else begin
            preset_n = preset_r;
          end
          if (edge_s[2] && !edge_s[3]) begin
            cursor_n = cursor_r + 2'd1;
          end else if (edge_s[3] && !edge_s[2]) begin
            cursor_n = cursor_r - 2'd1;
          end else begin
            cursor_n = cursor_r;
          end
        end
      end
      RUN: begin
        // finish outranks a simultaneous start edge.
        if (bus.finish) begin
          state_n     = ALARM;
          alarm_cnt_n = '0;
        end else if (edge_s[4]) begin
          state_n = PAUSE;
        end else begin
          state_n = RUN;
        end
      end
      PAUSE: begin
        if (edge_s[4]) begin
          state_n = RUN;
        end else if (|edge_s[3:0]) begin
          state_n = EDIT;
        end else begin
          state_n = PAUSE;
        end
      end
      ALARM: begin
        if (|edge_s) begin
          state_n = IDLE;
        end else if (bus.tick) begin
          if (alarm_cnt_r == ALARM_W'(ALARM_SECS - 32'd1)) begin
            state_n = IDLE;
          end else begin
            alarm_cnt_n = alarm_cnt_r + ALARM_W'(1);
          end
        end else begin
          state_n = ALARM;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Output decode from the next state so the registered outputs track it.
  always_comb begin
    go_n    = (state_n == RUN);
    alarm_n = (state_n == ALARM);
    case (state_n)
      EDIT:    blink_n = 4'b0001 << cursor_n;
      ALARM:   blink_n = 4'b1111;
      default: blink_n = 4'b0000;
    endcase
  end

  // State, datapath control and display registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      preset_r    <= 16'h0000;
      cursor_r    <= 2'd0;
      load_r      <= 1'b0;
      go_r        <= 1'b0;
      alarm_r     <= 1'b0;
      blink_r     <= 4'b0000;
      alarm_cnt_r <= '0;
      prev_r      <= 5'b00000;
    end else begin
      state_r     <= state_n;
      preset_r    <= preset_n;
      cursor_r    <= cursor_n;
      load_r      <= load_n;
      go_r        <= go_n;
      alarm_r     <= alarm_n;
      blink_r     <= blink_n;
      alarm_cnt_r <= alarm_cnt_n;
      prev_r      <= btn_s;
    end
  end

  assign bus.preset     = preset_r;
  assign bus.load       = load_r;
  assign bus.go         = go_r;
  assign bus.cursor     = cursor_r;
  assign bus.blink_mask = blink_r;
  assign bus.alarm      = alarm_r;
  assign bus.state      = state_r;

endmodule

// File: tb/tb_countdown_ctrl.sv
// -----------------------------------------------------------------------------
// tb_countdown_ctrl
// Directed stimulus for countdown_ctrl with a behavioural model (digits kept
// as integers, rules applied per clock) checked every cycle, plus literal
// expectations at key points.
// -----------------------------------------------------------------------------
module tb_countdown_ctrl;
  localparam int ALARM_SECS   = 3;
  localparam int REPEAT_DELAY = 20;
  localparam int REPEAT_RATE  = 5;

  localparam int B_UP = 0;
  localparam int B_DN = 1;
  localparam int B_L  = 2;
  localparam int B_R  = 3;
  localparam int B_ST = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] btn = 5'b00000;
  logic       tick_r = 1'b0;
  logic       fin_r = 1'b0;
  int         total = 0;
  int         bad = 0;

  countdown_ctrl_if bus();

  assign bus.up     = btn[B_UP];
  assign bus.down   = btn[B_DN];
  assign bus.left   = btn[B_L];
  assign bus.right  = btn[B_R];
  assign bus.start  = btn[B_ST];
  assign bus.tick   = tick_r;
  assign bus.finish = fin_r;

  countdown_ctrl #(
    .ALARM_SECS  (ALARM_SECS),
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE (REPEAT_RATE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  // Model state: st 0..4, digits d[3..0], cursor, load pulse, alarm ticks,
  // hold length for auto-repeat, previous button levels.
  typedef struct packed {
    int             st;
    logic [3:0][3:0] d;
    int             cur;
    logic           load;
    int             ticks;
    int             hold;
    logic [4:0]     prev;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.st = 0; r.d = 16'h0000; r.cur = 0; r.load = 1'b0;
    r.ticks = 0; r.hold = 0; r.prev = 5'b00000;
    return r;
  endfunction

  function automatic model_t model_step(input model_t o, input logic [4:0] lv,
                                        input logic tk, input logic fin);
    model_t n;
    logic [4:0] e;
    int lim;
    int c;
    logic us;
    logic ds;
    n = o;
    e = lv & ~o.prev;
    n.prev = lv;
    n.load = 1'b0;
    case (o.st)
      0: begin
        if (e[B_ST]) begin
          if (o.d != 16'h0000) begin n.st = 2; n.load = 1'b1; end
        end else if (|e[3:0]) n.st = 1;
      end
      1: begin
        if (e[B_ST]) begin
          if (o.d != 16'h0000) begin n.st = 2; n.load = 1'b1; end
          else n.st = 0;
        end else begin
          us = e[B_UP];
          ds = e[B_DN];
`ifdef AUTO_REPEAT_EN
          if (e[B_UP] || e[B_DN] || !(lv[B_UP] ^ lv[B_DN])) n.hold = 0;
          else begin
            n.hold = o.hold + 1;
            if (n.hold >= REPEAT_DELAY && (n.hold - REPEAT_DELAY) % REPEAT_RATE == 0) begin
              us = us | lv[B_UP];
              ds = ds | lv[B_DN];
            end
          end
`endif
          c = o.cur;
          lim = (c % 2 == 0) ? 10 : 6;
          if (us && !ds) n.d[c] = 4'((int'(o.d[c]) + 1) % lim);
          else if (ds && !us) n.d[c] = 4'((int'(o.d[c]) + lim - 1) % lim);
          if (e[B_L] && !e[B_R]) n.cur = (o.cur + 1) % 4;
          else if (e[B_R] && !e[B_L]) n.cur = (o.cur + 3) % 4;
        end
      end
      2: begin
        if (fin) begin n.st = 4; n.ticks = 0; end
        else if (e[B_ST]) n.st = 3;
      end
      3: begin
        if (e[B_ST]) n.st = 2;
        else if (|e[3:0]) n.st = 1;
      end
      4: begin
        if (|e) n.st = 0;
        else if (tk) begin
          n.ticks = o.ticks + 1;
          if (n.ticks == ALARM_SECS) n.st = 0;
        end
      end
      default: n.st = 0;
    endcase
    if (n.st != 1 || o.st != 1) n.hold = 0;
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= model_reset();
    else     m <= model_step(m, btn, tick_r, fin_r);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst) begin
      chk("m_state",  32'(bus.state),      32'(m.st));
      chk("m_preset", 32'(bus.preset),     32'(m.d));
      chk("m_cursor", 32'(bus.cursor),     32'(m.cur));
      chk("m_load",   32'(bus.load),       32'(m.load));
      chk("m_go",     32'(bus.go),         (m.st == 2) ? 32'd1 : 32'd0);
      chk("m_alarm",  32'(bus.alarm),      (m.st == 4) ? 32'd1 : 32'd0);
      chk("m_blink",  32'(bus.blink_mask),
          (m.st == 1) ? (32'd1 << m.cur) : ((m.st == 4) ? 32'hF : 32'h0));
    end
  end

  task automatic press(input int b);
    @(negedge clk); btn[b] = 1'b1;
    @(negedge clk); btn[b] = 1'b0;
  endtask

  task automatic pulse_tick();
    @(negedge clk); tick_r = 1'b1;
    @(negedge clk); tick_r = 1'b0;
  endtask

  initial begin
    #12;
    chk("rst_state",  32'(bus.state), 32'd0);
    chk("rst_preset", 32'(bus.preset), 32'h0000);
    chk("rst_go",     32'(bus.go), 32'd0);
    chk("rst_load",   32'(bus.load), 32'd0);
    chk("rst_blink",  32'(bus.blink_mask), 32'd0);
    @(negedge clk); rst = 1'b0;

    // Start with preset 0000 is ignored.
    press(B_ST);
    chk("zero_start_state", 32'(bus.state), 32'd0);
    chk("zero_start_load",  32'(bus.load), 32'd0);
    @(negedge clk);
    chk("zero_start_go",    32'(bus.go), 32'd0);

    // First edge enters EDIT only.
    press(B_UP);
    chk("enter_edit_state",  32'(bus.state), 32'd1);
    chk("enter_edit_preset", 32'(bus.preset), 32'h0000);
    repeat (12) press(B_UP);
    chk("wrap_up_preset", 32'(bus.preset), 32'h0002);
    press(B_L);
    press(B_DN);
    chk("left_cursor",   32'(bus.cursor), 32'd1);
    chk("down_wrap_preset", 32'(bus.preset), 32'h0052);
    press(B_L); press(B_L); press(B_R);
    chk("cursor_two",  32'(bus.cursor), 32'd2);
    chk("blink_edit",  32'(bus.blink_mask), 32'h4);

    // Build 01:30.
    press(B_UP);
    press(B_R); press(B_DN); press(B_DN);
    press(B_R); press(B_DN); press(B_DN);
    chk("preset_0130", 32'(bus.preset), 32'h0130);

    // Load / run / pause / resume.
    press(B_ST);
    chk("run_load",  32'(bus.load), 32'd1);
    chk("run_go",    32'(bus.go), 32'd1);
    chk("run_state", 32'(bus.state), 32'd2);
    @(negedge clk);
    chk("load_one_cycle", 32'(bus.load), 32'd0);
    press(B_ST);
    chk("pause_state", 32'(bus.state), 32'd3);
    chk("pause_go",    32'(bus.go), 32'd0);
    press(B_ST);
    chk("resume_state", 32'(bus.state), 32'd2);
    chk("resume_go",    32'(bus.go), 32'd1);
    chk("resume_load",  32'(bus.load), 32'd0);

    // Pause, edit from PAUSE, reload.
    press(B_ST);
    press(B_UP);
    chk("pause_edit_state",  32'(bus.state), 32'd1);
    chk("pause_edit_preset", 32'(bus.preset), 32'h0130);
    press(B_ST);
    chk("reload_load", 32'(bus.load), 32'd1);

    // Asynchronous reset while running.
    @(negedge clk); #2 rst = 1'b1;
    #1;
    chk("arst_go",     32'(bus.go), 32'd0);
    chk("arst_state",  32'(bus.state), 32'd0);
    chk("arst_preset", 32'(bus.preset), 32'h0000);
    chk("arst_cursor", 32'(bus.cursor), 32'd0);
    chk("arst_alarm",  32'(bus.alarm), 32'd0);
    @(negedge clk); rst = 1'b0;

    // Alarm with finish and start in the same cycle, then tick timeout.
    press(B_UP); press(B_UP); press(B_ST);
    @(negedge clk); fin_r = 1'b1; btn[B_ST] = 1'b1;
    @(negedge clk); fin_r = 1'b0; btn[B_ST] = 1'b0;
    chk("alarm_state", 32'(bus.state), 32'd4);
    chk("alarm_flag",  32'(bus.alarm), 32'd1);
    chk("alarm_blink", 32'(bus.blink_mask), 32'hF);
    chk("alarm_go",    32'(bus.go), 32'd0);
    pulse_tick(); pulse_tick();
    chk("alarm_two_ticks", 32'(bus.state), 32'd4);
    pulse_tick();
    chk("alarm_timeout_state",  32'(bus.state), 32'd0);
    chk("alarm_timeout_alarm",  32'(bus.alarm), 32'd0);
    chk("alarm_timeout_preset", 32'(bus.preset), 32'h0001);

    // Alarm acknowledged by a button edge.
    press(B_ST);
    @(negedge clk); fin_r = 1'b1;
    @(negedge clk); fin_r = 1'b0;
    chk("alarm2_state", 32'(bus.state), 32'd4);
    press(B_L);
    chk("ack_state", 32'(bus.state), 32'd0);
    chk("ack_alarm", 32'(bus.alarm), 32'd0);

    // Hold up for 40 cycles on digit 0 starting from 0.
    press(B_UP); press(B_DN);
    chk("hold_start", 32'(bus.preset), 32'h0000);
    @(negedge clk); btn[B_UP] = 1'b1;
    repeat (40) @(negedge clk);
    btn[B_UP] = 1'b0;
    @(negedge clk);
`ifdef AUTO_REPEAT_EN
    chk("hold_repeat", 32'(bus.preset), 32'h0005);
`else
    chk("hold_repeat", 32'(bus.preset), 32'h0001);
`endif

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/countdown_ctrl.md
Name: countdown_ctrl

Overview:
- Sequencing controller for the countdown timer datapath.
- Turns debounced up/down/left/right/start button levels into preset editing, a load pulse, a count-enable, and alarm handling.
- Sits between the button inputs and the countdown counter.
- Feeds preset/cursor/blink information to the display path (words/BCD encoder).

Parameters:
ALARM_SECS, 10, number of tick pulses the alarm stays active before auto-return to IDLE
REPEAT_DELAY, 50000000, clk cycles up/down must be held before auto-repeat starts (AUTO_REPEAT_EN only)
REPEAT_RATE, 10000000, clk cycles between auto-repeat steps (AUTO_REPEAT_EN only)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  asynchronous, active-high reset
tick  input  1  one-clk-wide 1 Hz enable pulse, synchronous to clk
up, down, left, right, start  input  1 each  debounced, synchronous button levels
finish  input  1  datapath count has reached 0000 (level)
preset  output  16  BCD MM:SS preset; [15:12] min tens, [11:8] min units, [7:4] sec tens, [3:0] sec units
load  output  1  one-cycle pulse: datapath loads preset
go  output  1  count enable to datapath
cursor  output  2  digit under edit; 0 = [3:0] ... 3 = [15:12]
blink_mask  output  4  per-digit blink request to display
alarm  output  1  alarm active
state  output  3  IDLE=0, EDIT=1, RUN=2, PAUSE=3, ALARM=4

Behaviour:
- One clock, `clk`; reset is `rst`, asynchronous and active-high.
- Reset values: state=IDLE, preset=16'h0000, cursor=0, load=0, go=0, alarm=0, blink_mask=0. Edge-detect registers clear to 0.
- Reset mid-operation drops go/load immediately.
- Edge detection:
  - Each button has a prev register; edge = level & ~prev.
  - An edge sampled at clock edge N takes effect in registered outputs at edge N.
  - One edge = one action.
- All outputs are registered.
- IDLE:
  - Any up/down/left/right edge goes to EDIT; that edge is consumed and does not change the digit.
  - A start edge with preset != 0 goes to RUN with load=1.
  - A start edge with preset == 0 is ignored.
- EDIT:
  - up/down increments/decrements digit[cursor] with wrap.
  - Digit ranges: digits 0 and 2 are 0-9; digits 1 and 3 are 0-5 (max preset 59:59).
  - left: cursor+1 mod 4. right: cursor-1 mod 4.
  - Simultaneous up+down edges: no change. Simultaneous left+right edges: no change.
  - Simultaneous digit and cursor edges: the digit is edited at the old cursor, then the cursor moves.
  - A start edge with preset != 0 goes to RUN with load=1; with preset == 0 it goes to IDLE.
- RUN:
  - go=1 from the same edge that asserts load. load is high exactly one cycle.
  - finish=1 goes to ALARM, go=0.
  - A start edge goes to PAUSE, go=0.
  - If finish and a start edge occur in the same cycle, finish wins.
- PAUSE:
  - go=0.
  - A start edge returns to RUN with go=1 and no load (resume).
  - An up/down/left/right edge goes to EDIT (consumed, as in IDLE); the next start reloads.
- ALARM:
  - alarm=1, blink_mask=4'b1111.
  - An internal counter counts tick pulses; the counter is cleared on entry.
  - After ALARM_SECS ticks, goes to IDLE.
  - Any button edge goes to IDLE immediately (acknowledge).
  - preset is retained.
- blink_mask: in EDIT, one-hot bit[cursor]; in ALARM, 4'b1111; otherwise 0.
- go and load are never asserted outside RUN entry/RUN.

Optional Feature:
- Macro: AUTO_REPEAT_EN.
- When defined:
  - In EDIT, holding up (or down) alone continuously for REPEAT_DELAY cycles after its edge generates an extra step.
  - Further steps follow every REPEAT_RATE cycles until release.
  - The repeat counter clears on release, on state change, or when both are held.
- When undefined: only edges step digits; REPEAT_* parameters are unused and no repeat counter is synthesised.

Test Plan:
- Reset during RUN with preset 16'h0130 -> same-cycle go=0, state=0, preset=16'h0000, cursor=0, alarm=0.
- IDLE: up edge -> state=1, preset 0000. Then 12 up edges -> preset[3:0]=2. Then left, down -> cursor=1, preset=16'h0052. Then left, left, right -> cursor=2.
- IDLE, preset 0000, start edge -> state stays 0, load never 1, go=0.
- preset 0130, start edge -> load=1 for exactly one cycle, go=1, state=2. Start -> state=3, go=0. Start -> state=2, go=1, load stays 0.
- ALARM_SECS=3, RUN: finish and start edge in the same cycle -> state=4, alarm=1, blink_mask=1111. Three tick pulses -> state=0, alarm=0, preset unchanged. Repeat with a left edge during ALARM -> IDLE on next edge.
- AUTO_REPEAT_EN, REPEAT_DELAY=20, REPEAT_RATE=5: in EDIT, hold up 40 cycles on digit0 from 0 -> digit0=5 (1 edge + 4 repeats). Same test without the macro -> digit0=1.
